systolic_array_8x8: RTL and testbench

Output-stationary 8x8 systolic matrix multiplier computing C = A·B for signed 8-bit operands with 32-bit accumulation. It is the compute tile of the NPU datapath. The 16x16 block-matrix engine instantiates four of these tiles and runs them in lock-step, loading two phases of 8x8 sub-blocks and summing the partial products. Each job is one operand load plus a fixed-latency compute, ending in a single-cycle result-valid pulse.

---
 rtl/systolic_array_8x8.sv | 121 ++++++++++++
 tb/tb_systolic_array_8x8.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_8x8.sv
// Output-stationary 8x8 systolic multiplier: C = A*B, signed 8-bit operands, 32-bit accumulators.
// One job: capture at E0, 22 skewed accumulate steps (E1..E22), result register plus 1-cycle valid at E23.
module systolic_array_8x8 (
  input  logic                         i_clk,
  input  logic                         i_arst,
  input  logic                         i_validInput,
  input  logic signed [7:0][7:0][7:0]  i_a,
  input  logic signed [7:0][7:0][7:0]  i_b,
  output logic signed [7:0][7:0][31:0] o_c,
  output logic                         o_validResult
);
  localparam int N      = 8;
  localparam int LAST_T = 21;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                    state_q;
  logic [4:0]                t_q;
  logic signed [7:0]         a_op_q   [N][N];
  logic signed [7:0]         b_op_q   [N][N];
  logic signed [7:0]         a_pipe_q [N][N];
  logic signed [7:0]         b_pipe_q [N][N];
  logic signed [31:0]        acc_q    [N][N];
  logic signed [7:0][7:0][31:0] c_q;
  logic                      valid_q;

  logic signed [7:0]         a_in [N][N];
  logic signed [7:0]         b_in [N][N];
  int                        k_a;
  int                        k_b;

  function automatic logic signed [31:0] mac(input logic signed [31:0] acc,
                                             input logic signed [7:0]  a,
                                             input logic signed [7:0]  b);
    logic signed [15:0] prod;
    prod = a * b;
    return acc + {{16{prod[15]}}, prod};
  endfunction

  // Edge PEs take the skewed operand (A[i][t-i], B[t-j][j]) or zero; inner PEs take their neighbour's last value.
  always_comb begin
    k_a = 0;
    k_b = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        a_in[i][j] = '0;
        b_in[i][j] = '0;
      end
    end
    for (int i = 0; i < N; i++) begin
      k_a = int'(t_q) - i;
      if (k_a >= 0 && k_a < N) a_in[i][0] = a_op_q[i][k_a[2:0]];
      for (int j = 1; j < N; j++) a_in[i][j] = a_pipe_q[i][j-1];
    end
    for (int j = 0; j < N; j++) begin
      k_b = int'(t_q) - j;
      if (k_b >= 0 && k_b < N) b_in[0][j] = b_op_q[k_b[2:0]][j];
      for (int i = 1; i < N; i++) b_in[i][j] = b_pipe_q[i-1][j];
    end
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state_q <= IDLE;
      t_q     <= '0;
      valid_q <= 1'b0;
      c_q     <= '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_op_q[i][j]   <= '0;
          b_op_q[i][j]   <= '0;
          a_pipe_q[i][j] <= '0;
          b_pipe_q[i][j] <= '0;
          acc_q[i][j]    <= '0;
        end
      end
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_validInput) begin
            t_q     <= '0;
            state_q <= RUN;
            for (int i = 0; i < N; i++) begin
              for (int j = 0; j < N; j++) begin
                a_op_q[i][j]   <= i_a[i][j];
                b_op_q[i][j]   <= i_b[i][j];
                a_pipe_q[i][j] <= '0;
                b_pipe_q[i][j] <= '0;
                acc_q[i][j]    <= '0;
              end
            end
          end
        end
        RUN: begin
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
              acc_q[i][j]    <= mac(acc_q[i][j], a_in[i][j], b_in[i][j]);
              a_pipe_q[i][j] <= a_in[i][j];
              b_pipe_q[i][j] <= b_in[i][j];
            end
          end
          t_q <= t_q + 5'd1;
          if (t_q == 5'(LAST_T)) state_q <= DONE;
        end
        DONE: begin
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) c_q[i][j] <= acc_q[i][j];
          end
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_c           = c_q;
  assign o_validResult = valid_q;

endmodule

// File: tb/tb_systolic_array_8x8.sv
// Directed bench for systolic_array_8x8: latency, identity, sign extremes, back-to-back, ignored strobe, mid-job reset.
module tb_systolic_array_8x8;
  typedef logic signed [7:0][7:0][7:0]  mat8_t;
  typedef logic signed [7:0][7:0][31:0] mat32_t;

  logic   i_clk = 1'b0;
  logic   i_arst;
  logic   i_validInput;
  mat8_t  i_a;
  mat8_t  i_b;
  mat32_t o_c;
  logic   o_validResult;

  int n_checks = 0;
  int n_errors = 0;

  systolic_array_8x8 dut (
    .i_clk         (i_clk),
    .i_arst        (i_arst),
    .i_validInput  (i_validInput),
    .i_a           (i_a),
    .i_b           (i_b),
    .o_c           (o_c),
    .o_validResult (o_validResult)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_mat(input string tag, input mat32_t exp);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        chk($sformatf("%s_c%0d%0d", tag, i, j), int'(o_c[i][j]), int'(exp[i][j]));
  endtask

  function automatic mat32_t ref_mul(input mat8_t a, input mat8_t b);
    mat32_t c;
    int s;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        s = 0;
        for (int k = 0; k < 8; k++)
          s += int'($signed(a[i][k])) * int'($signed(b[k][j]));
        c[i][j] = 32'(s);
      end
    return c;
  endfunction

  function automatic mat8_t rand_mat();
    mat8_t m;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) m[i][j] = 8'($urandom);
    return m;
  endfunction

  function automatic mat8_t fill8(input logic [7:0] v);
    mat8_t m;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) m[i][j] = v;
    return m;
  endfunction

  function automatic mat32_t fill32(input int v);
    mat32_t m;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) m[i][j] = 32'(v);
    return m;
  endfunction

  function automatic int nonzero_count();
    int n = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) if (o_c[i][j] != '0) n++;
    return n;
  endfunction

  // Called 1ns after a rising edge; the strobe is sampled at the next edge (E0).
  task automatic launch(input mat8_t a, input mat8_t b);
    i_a = a;
    i_b = b;
    i_validInput = 1'b1;
    @(posedge i_clk);
    #1;
    i_validInput = 1'b0;
    i_a = rand_mat();
    i_b = rand_mat();
  endtask

  // Returns number of edges until the valid pulse is seen, or -1 after a bounded wait.
  task automatic wait_result(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge i_clk);
      #1;
      if (o_validResult) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge i_clk);
      #1;
      if (o_validResult) n++;
    end
  endtask

  initial begin
    mat8_t  a_id, b_id, ra, rb, ra2, rb2;
    mat32_t exp_id, exp1, exp2;
    int lat, n;

    i_arst = 1'b0;
    i_validInput = 1'b0;
    i_a = '0;
    i_b = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", int'(o_validResult), 0);
    chk("rst_c_nonzero", nonzero_count(), 0);
    i_arst = 1'b1;

    // Identity A, B[r][c] = r*8+c-32
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        a_id[r][c]   = (r == c) ? 8'sd1 : 8'sd0;
        b_id[r][c]   = 8'(r * 8 + c - 32);
        exp_id[r][c] = 32'(r * 8 + c - 32);
      end
    launch(a_id, b_id);
    wait_result(lat);
    chk("id_latency", lat, 23);
    chk_mat("id", exp_id);
    @(posedge i_clk);
    #1;
    chk("id_valid_one_cycle", int'(o_validResult), 0);
    chk_mat("id_hold", exp_id);

    launch(fill8(8'h80), fill8(8'h80));
    wait_result(lat);
    chk("neg_latency", lat, 23);
    chk_mat("neg", fill32(131072));

    launch(fill8(8'h7f), fill8(8'h80));
    wait_result(lat);
    chk("mix_latency", lat, 23);
    chk_mat("mix", fill32(-130048));

    // Random job, then a second job accepted at E24
    ra = rand_mat(); rb = rand_mat(); exp1 = ref_mul(ra, rb);
    ra2 = rand_mat(); rb2 = rand_mat(); exp2 = ref_mul(ra2, rb2);
    launch(ra, rb);
    wait_result(lat);
    chk("rnd1_latency", lat, 23);
    chk_mat("rnd1", exp1);
    launch(ra2, rb2);
    chk("rnd2_valid_drop", int'(o_validResult), 0);
    wait_result(lat);
    chk("rnd2_latency", lat, 23);
    chk_mat("rnd2", exp2);

    // Strobe at E5 with other data must be ignored
    ra = rand_mat(); rb = rand_mat(); exp1 = ref_mul(ra, rb);
    launch(ra, rb);
    repeat (4) @(posedge i_clk);
    #1;
    i_a = fill8(8'h80);
    i_b = fill8(8'h7f);
    i_validInput = 1'b1;
    @(posedge i_clk);
    #1;
    i_validInput = 1'b0;
    wait_result(lat);
    chk("runstrobe_latency", lat, 18);
    chk_mat("runstrobe", exp1);
    count_pulses(30, n);
    chk("runstrobe_extra_pulses", n, 0);

    // Reset at E10 aborts the job
    launch(rand_mat(), rand_mat());
    repeat (10) @(posedge i_clk);
    #1;
    i_arst = 1'b0;
    #2;
    chk("midrst_valid", int'(o_validResult), 0);
    chk("midrst_c_nonzero_async", nonzero_count(), 0);
    @(posedge i_clk);
    #1;
    i_arst = 1'b1;
    count_pulses(30, n);
    chk("midrst_pulses", n, 0);
    chk("midrst_c_nonzero", nonzero_count(), 0);

    ra = rand_mat(); rb = rand_mat(); exp1 = ref_mul(ra, rb);
    launch(ra, rb);
    wait_result(lat);
    chk("post_rst_latency", lat, 23);
    chk_mat("post_rst", exp1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
